// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store data; grants are combinational, read data returns one cycle after grant.
// Optional MEM_ARB_RR_EN: round-robin contention instead of data priority with a MAX_HOLD starvation guard.
module mem_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;

  owner_e      rd_owner_q, rd_owner_d;
  logic [15:0] if_rdata_q, d_rdata_q;
  logic        if_win, d_win;
  logic        contend;

  assign contend = if_req & d_req;

`ifdef MEM_ARB_RR_EN
  logic last_d_q;

  always_comb begin
    if_win = if_req;
    d_win  = d_req;
    if (contend) begin
      if_win = last_d_q;
      d_win  = ~last_d_q;
    end
  end

  // Only contended cycles move the round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         last_d_q <= 1'b1;
    else if (contend) last_d_q <= d_win;
  end
`else
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       fetch_forced;

  assign fetch_forced = (hold_cnt_q == 4'(MAX_HOLD));

  always_comb begin
    if_win = if_req;
    d_win  = d_req;
    if (contend) begin
      if_win = fetch_forced;
      d_win  = ~fetch_forced;
    end
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (!if_req || if_win)
      hold_cnt_d = 4'd0;
    else if (d_win && (hold_cnt_q < 4'(MAX_HOLD)))
      hold_cnt_d = hold_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hold_cnt_q <= 4'd0;
    else      hold_cnt_q <= hold_cnt_d;
  end
`endif

  // Reset gates the combinational request path so nothing reaches memory while rst is low.
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = 16'd0;
    mem_wdata = 16'd0;
    if (rst) begin
      if (if_win) begin
        if_gnt   = 1'b1;
        mem_ren  = 1'b1;
        mem_addr = if_addr;
      end else if (d_win) begin
        d_gnt     = 1'b1;
        mem_ren   = ~d_we;
        mem_wen   = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
    end
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (if_gnt)              rd_owner_d = OWN_IF;
    else if (d_gnt && !d_we) rd_owner_d = OWN_D;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_owner_q <= OWN_NONE;
      if_rdata_q <= 16'd0;
      d_rdata_q  <= 16'd0;
    end else begin
      rd_owner_q <= rd_owner_d;
      if (rd_owner_q == OWN_IF) if_rdata_q <= mem_rdata;
      if (rd_owner_q == OWN_D)  d_rdata_q  <= mem_rdata;
    end
  end

  // Owner sees live memory data; the other port keeps showing its last response.
  assign if_rvalid = (rd_owner_q == OWN_IF);
  assign d_rvalid  = (rd_owner_q == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
  assign d_rdata   = d_rvalid  ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read memory model; honours MEM_ARB_RR_EN.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [15:0] if_rdata, d_rdata;
  logic        mem_ren, mem_wen;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        pl_en;
  logic [7:0]  pl_a;
  logic [15:0] pl_d;
  logic [15:0] tmem [0:255];

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) tmem[pl_a] <= pl_d;
    else if (mem_wen) tmem[mem_addr[7:0]] <= mem_wdata;
    if (mem_ren) mem_rdata <= tmem[mem_addr[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        if_req;
    logic [15:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [3:0]  e_ctl;   // {if_gnt, d_gnt, mem_ren, mem_wen}
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic [1:0]  e_rv;    // {if_rvalid, d_rvalid}
    logic [15:0] e_ifrd;
    logic [15:0] e_drd;
  } vec_t;

  vec_t vec [0:6];
  logic [15:0] pl_addr [0:3];
  logic [15:0] pl_data [0:3];

  initial begin
    vec[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b1010, 16'h0010, 16'h0000, 2'b00, 16'h0000, 16'h0000};
    vec[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0020, 16'hBEEF, 4'b0101, 16'h0020, 16'hBEEF, 2'b10, 16'h1234, 16'h0000};
    vec[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 16'h0000, 4'b0110, 16'h0020, 16'h0000, 2'b00, 16'h1234, 16'h0000};
    vec[3] = '{1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b1010, 16'h0001, 16'h0000, 2'b01, 16'h1234, 16'hBEEF};
    vec[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'h0000, 4'b0110, 16'h0002, 16'h0000, 2'b10, 16'hAAAA, 16'hBEEF};
    vec[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 2'b01, 16'hAAAA, 16'h5555};
    vec[6] = '{1'b0, 16'h0033, 1'b0, 1'b1, 16'h0099, 16'h7777, 4'b0000, 16'h0000, 16'h0000, 2'b00, 16'hAAAA, 16'h5555};
    pl_addr[0] = 16'h0010; pl_data[0] = 16'h1234;
    pl_addr[1] = 16'h0001; pl_data[1] = 16'hAAAA;
    pl_addr[2] = 16'h0002; pl_data[2] = 16'h5555;
    pl_addr[3] = 16'h0050; pl_data[3] = 16'h0000;

    rst = 1'b0; pl_en = 1'b0; pl_a = 8'd0; pl_d = 16'd0;
    if_req = 1'b1; if_addr = 16'h0050;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'h0777;

    // Reset held with both requests active; memory preloaded meanwhile.
    for (int i = 0; i < 4; i++) begin
      pl_en = 1'b1; pl_a = pl_addr[i][7:0]; pl_d = pl_data[i];
      #2;
      chk("rst_ctl", {if_gnt, d_gnt, mem_ren, mem_wen, if_rvalid, d_rvalid}, 32'd0);
      chk("rst_bus", {mem_addr, mem_wdata}, 32'd0);
      chk("rst_rdata", {if_rdata, d_rdata}, 32'd0);
      next_cycle();
    end
    pl_en = 1'b0;
    rst = 1'b1;
    #1;
`ifdef MEM_ARB_RR_EN
    chk("release_grant", {if_gnt, d_gnt, mem_ren, mem_wen}, 32'b1010);
    chk("release_addr", {16'd0, mem_addr}, 32'h0050);
`else
    chk("release_grant", {if_gnt, d_gnt, mem_ren, mem_wen}, 32'b0101);
    chk("release_addr", {mem_addr, mem_wdata}, 32'h0030_0777);
`endif
    next_cycle();
    if_req = 1'b0; d_req = 1'b0;
    next_cycle();

    for (int i = 0; i < 7; i++) begin
      if_req = vec[i].if_req; if_addr = vec[i].if_addr;
      d_req = vec[i].d_req; d_we = vec[i].d_we;
      d_addr = vec[i].d_addr; d_wdata = vec[i].d_wdata;
      #2;
      chk($sformatf("v%0d_ctl", i), {28'd0, if_gnt, d_gnt, mem_ren, mem_wen}, {28'd0, vec[i].e_ctl});
      chk($sformatf("v%0d_bus", i), {mem_addr, mem_wdata}, {vec[i].e_addr, vec[i].e_wdata});
      chk($sformatf("v%0d_rv", i), {30'd0, if_rvalid, d_rvalid}, {30'd0, vec[i].e_rv});
      chk($sformatf("v%0d_rdata", i), {if_rdata, d_rdata}, {vec[i].e_ifrd, vec[i].e_drd});
      next_cycle();
    end

    // Continuous contention: fetch reads 0x0001, data reads 0x0002.
    if_req = 1'b1; if_addr = 16'h0001;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0002; d_wdata = 16'h0000;
    begin
      logic prev_if;
      logic exp_if;
      prev_if = 1'b0;
      for (int k = 0; k < 10; k++) begin
        #2;
`ifdef MEM_ARB_RR_EN
        // Fetch won the contended release cycle, so data goes first here.
        exp_if = (k % 2) == 1;
`else
        exp_if = (k % 5) == 4;
`endif
        chk($sformatf("cont%0d_gnt", k), {30'd0, if_gnt, d_gnt}, {30'd0, exp_if, ~exp_if});
        chk($sformatf("cont%0d_addr", k), {16'd0, mem_addr}, exp_if ? 32'h0001 : 32'h0002);
        if (k > 0) begin
          chk($sformatf("cont%0d_rv", k), {30'd0, if_rvalid, d_rvalid}, {30'd0, prev_if, ~prev_if});
          chk($sformatf("cont%0d_rd", k), {16'd0, prev_if ? if_rdata : d_rdata},
              prev_if ? 32'hAAAA : 32'h5555);
        end
        prev_if = exp_if;
        next_cycle();
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    next_cycle();
    next_cycle();

    // Reset in the response cycle drops the pending fetch read.
    if_req = 1'b1; if_addr = 16'h0010;
    #1;
    chk("mid_gnt", {31'd0, if_gnt}, 32'd1);
    next_cycle();
    if_req = 1'b0;
    #1;
    chk("mid_rv_before", {31'd0, if_rvalid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rv_async", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    chk("mid_rdata", {if_rdata, d_rdata}, 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("post_rst%0d", k), {28'd0, if_gnt, d_gnt, if_rvalid, d_rvalid}, 32'd0);
      next_cycle();
    end
    if_req = 1'b1; if_addr = 16'h0010;
    #1;
    chk("reissue_gnt", {31'd0, if_gnt}, 32'd1);
    next_cycle();
    if_req = 1'b0;
    #1;
    chk("reissue_rv", {15'd0, if_rvalid, if_rdata}, {15'd0, 1'b1, 16'h1234});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
